// File: rtl/tile_mapper_pkg.sv
// Shared types and helpers for the scrolling tile mapper.
// Modular reduction is built from compare-subtract steps only.
package tile_mapper_pkg;

    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned V_ACTIVE = 480;
    localparam int unsigned COORD_W  = 10;

    typedef logic [COORD_W-1:0] coord_t;

    typedef struct packed {
        logic [3:0] red;
        logic [3:0] green;
        logic [3:0] blue;
    } rgb4_t;

    // (a + b) mod lim, valid when both a and b are already below lim
    function automatic coord_t wrap_add(input coord_t a, input coord_t b, input coord_t lim);
        logic [COORD_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, lim}) begin
            s = s - {1'b0, lim};
        end
        return s[COORD_W-1:0];
    endfunction

    // Bounded chain of compare-subtracts; iters is an elaboration-time constant
    function automatic coord_t mod_reduce(input coord_t a, input coord_t lim, input int unsigned iters);
        coord_t r;
        r = a;
        for (int unsigned i = 0; i < iters; i++) begin
            if (r >= lim) begin
                r = r - lim;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/pipe_delay.sv
// Fixed-depth shift register with synchronous active-low clear.
module pipe_delay #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= d;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[DEPTH-1];

endmodule

// File: rtl/tile_scroll_mapper.sv
// Repeating scaled background tile with frame-synchronous scrolling.
// Drives tile ROM + palette and aligns blank across the ROM latency.
module tile_scroll_mapper
    import tile_mapper_pkg::*;
#(
    parameter int unsigned TILE_W     = 96,
    parameter int unsigned TILE_H     = 96,
    parameter int unsigned IDX_W      = 3,
    parameter int unsigned SCALE_LOG2 = 2,
    parameter int unsigned ROM_LAT    = 1,
    parameter int unsigned H_ACTIVE   = tile_mapper_pkg::H_ACTIVE,
    parameter int unsigned V_ACTIVE   = tile_mapper_pkg::V_ACTIVE,
    parameter int unsigned ADDR_W     = 15
) (
    input  logic              vga_clk,
    input  logic              reset_n,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              blank,
    input  logic [9:0]        scroll_x_in,
    input  logic [9:0]        scroll_y_in,
    input  logic              scroll_valid,
    output logic              scroll_ready,
    output logic [ADDR_W-1:0] rom_address,
    input  logic [IDX_W-1:0]  rom_q,
    output logic [IDX_W-1:0]  pal_index,
    input  logic [3:0]        pal_red,
    input  logic [3:0]        pal_green,
    input  logic [3:0]        pal_blue,
    output logic [3:0]        red,
    output logic [3:0]        green,
    output logic [3:0]        blue,
    output logic              opaque
);

    localparam coord_t      TW        = coord_t'(TILE_W);
    localparam coord_t      TH        = coord_t'(TILE_H);
    localparam coord_t      FRAME_ROW = coord_t'(V_ACTIVE);
    // Subtract steps needed to bring a visible scaled coordinate below the tile size
    localparam int unsigned COL_ITERS = ((H_ACTIVE - 1) >> SCALE_LOG2) / TILE_W;
    localparam int unsigned ROW_ITERS = ((V_ACTIVE - 1) >> SCALE_LOG2) / TILE_H;
    localparam int unsigned SX_ITERS  = ((2 ** COORD_W) - 1) / TILE_W;
    localparam int unsigned SY_ITERS  = ((2 ** COORD_W) - 1) / TILE_H;

    coord_t act_x, act_y, pend_x, pend_y;
    coord_t tx, ty;
    logic   pending;
    logic   boundary, accept;
    logic   blank_d;
    rgb4_t  colour;

    always_comb begin
        tx       = wrap_add(mod_reduce(DrawX >> SCALE_LOG2, TW, COL_ITERS), act_x, TW);
        ty       = wrap_add(mod_reduce(DrawY >> SCALE_LOG2, TH, ROW_ITERS), act_y, TH);
        boundary = (DrawX == '0) && (DrawY == FRAME_ROW);
        accept   = scroll_valid && scroll_ready;
    end

    // Texel address, one cycle after DrawX/DrawY
    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            rom_address <= '0;
        end else begin
            rom_address <= ADDR_W'(ty) * ADDR_W'(TILE_W) + ADDR_W'(tx);
        end
    end

    // Pending request is promoted only at the frame boundary, so a frame never tears
    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            act_x        <= '0;
            act_y        <= '0;
            pend_x       <= '0;
            pend_y       <= '0;
            pending      <= 1'b0;
            scroll_ready <= 1'b1;
        end else begin
            if (boundary && pending) begin
                act_x        <= pend_x;
                act_y        <= pend_y;
                pending      <= 1'b0;
                scroll_ready <= 1'b1;
            end
            if (accept) begin
                pend_x       <= mod_reduce(scroll_x_in, TW, SX_ITERS);
                pend_y       <= mod_reduce(scroll_y_in, TH, SY_ITERS);
                pending      <= 1'b1;
                scroll_ready <= 1'b0;
            end
        end
    end

    pipe_delay #(
        .WIDTH (1),
        .DEPTH (ROM_LAT + 1)
    ) u_blank_delay (
        .clk   (vga_clk),
        .rst_n (reset_n),
        .d     (blank),
        .q     (blank_d)
    );

    assign pal_index = rom_q;

    // Index 0 keeps its palette colour; only opaque marks it transparent
    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            colour <= '0;
            opaque <= 1'b0;
        end else if (blank_d) begin
            colour <= rgb4_t'{red: pal_red, green: pal_green, blue: pal_blue};
            opaque <= (rom_q != '0);
        end else begin
            colour <= '0;
            opaque <= 1'b0;
        end
    end

    assign red   = colour.red;
    assign green = colour.green;
    assign blue  = colour.blue;

endmodule
